// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one 32-bit ALU between two requesters.
// A request is accepted through valid/ready and executed in the accept
// cycle. The registered result and flags {N,Z,C,V} go back on the
// winner's response channel, which has valid/ready backpressure.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   reqN_valid/ready        request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_op operands and ALU op (00 add, 01 sub, 10 and, 11 or)
//   rspN_valid/ready        response handshake for requester N
//   rspN_result, rspN_flags registered result and {N,Z,C,V}
//   busy                    high while a response is held
//
// Build option: define ALU_SHARE_RR_EN for round-robin tie-breaking.
// Without it, requester 0 has fixed priority.
//
// state | meaning
// IDLE  | no response held
// RESP  | one response held for owner

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  logic [31:0] b_x;
  logic [32:0] sum;
  logic        c;
  logic        v;

  // Subtraction is a + ~b + 1, so its carry-out means "no borrow".
  always_comb begin
    b_x    = op[0] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_x} + {32'd0, op[0]};
    c      = 1'b0;
    v      = 1'b0;
    result = 32'd0;
    case (op)
      2'b00, 2'b01: begin
        result = sum[31:0];
        c      = sum[32];
        v      = (a[31] == b_x[31]) && (sum[31] != a[31]);
      end
      2'b10:   result = a & b;
      default: result = a | b;
    endcase
    flags = {result[31], (result == 32'd0), c, v};
  end
endmodule

module alu_share_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,
  output logic        busy
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic        owner;
  logic [31:0] result_q;
  logic [3:0]  flags_q;
  logic        grant0;
  logic        grant1;
  logic        rsp_hs;
  logic        open;
  logic        accept;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

`ifdef ALU_SHARE_RR_EN
  logic last;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last);
    grant1 = req1_valid && (!req0_valid || !last);
  end
`else
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid && !req0_valid;
  end
`endif

  always_comb begin
    rsp_hs = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    // A slot opens when nothing is held or the held response leaves now.
    open   = !reset && (state == IDLE || rsp_hs);
    req0_ready = grant0 && open;
    req1_ready = grant1 && open;
    accept = (grant0 || grant1) && open;
    alu_a  = grant1 ? req1_a  : req0_a;
    alu_b  = grant1 ? req1_b  : req0_b;
    alu_op = grant1 ? req1_op : req0_op;
  end

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
`ifdef ALU_SHARE_RR_EN
      last       <= 1'b1;
`endif
      result_q   <= 32'd0;
      flags_q    <= 4'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      state      <= RESP;
      owner      <= grant1;
`ifdef ALU_SHARE_RR_EN
      last       <= grant1;
`endif
      result_q   <= alu_result;
      flags_q    <= alu_flags;
      rsp0_valid <= !grant1;
      rsp1_valid <= grant1;
      busy       <= 1'b1;
    end else if (rsp_hs) begin
      state      <= IDLE;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end
  end

  always_comb begin
    rsp0_result = result_q;
    rsp0_flags  = flags_q;
    rsp1_result = result_q;
    rsp1_flags  = flags_q;
  end
endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic [1:0]  req0_op;
  logic [3:0]  rsp0_flags;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [1:0]  req1_op;
  logic [3:0]  rsp1_flags;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   m_pend = -1;
  int   m_last = 1;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op), .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op), .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain arithmetic on wide/signed values.
  function automatic exp_t ref_alu(input logic port, input logic [31:0] a,
                                   input logic [31:0] b, input logic [1:0] op);
    exp_t   e;
    longint sv;
    logic   c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      2'd0: begin
        e.r = a + b;
        c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        sv  = longint'($signed(a)) + longint'($signed(b));
        v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      2'd1: begin
        e.r = a - b;
        c   = (a >= b);
        sv  = longint'($signed(a)) - longint'($signed(b));
        v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      2'd2:    e.r = a & b;
      default: e.r = a | b;
    endcase
    e.port = port;
    e.f    = {e.r[31], e.r == 32'd0, c, v};
    return e;
  endfunction

  // Reference model: arbitration and response-holding rules per cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("ready0_in_reset", req0_ready, 0);
      chk("ready1_in_reset", req1_ready, 0);
      m_pend = -1;
      m_last = 1;
      sb.delete();
    end else begin
      bit hs, can;
      int w;
      hs  = (m_pend == 0 && rsp0_ready) || (m_pend == 1 && rsp1_ready);
      can = (m_pend < 0) || hs;
      w   = -1;
      if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_RR_EN
        w = (m_last == 1) ? 0 : 1;
`else
        w = 0;
`endif
      end else if (req0_valid) w = 0;
      else if (req1_valid) w = 1;
      chk("req0_ready", req0_ready, (can && w == 0));
      chk("req1_ready", req1_ready, (can && w == 1));
      chk("rsp0_valid", rsp0_valid, (m_pend == 0));
      chk("rsp1_valid", rsp1_valid, (m_pend == 1));
      chk("busy", busy, (m_pend >= 0));
      if (req0_valid && req0_ready) glog.push_back(0);
      else if (req1_valid && req1_ready) glog.push_back(1);
      if (can && w >= 0) begin
        if (w == 0) sb.push_back(ref_alu(1'b0, req0_a, req0_b, req0_op));
        else        sb.push_back(ref_alu(1'b1, req1_a, req1_b, req1_op));
        m_pend = w;
        m_last = w;
      end else if (hs) begin
        m_pend = -1;
      end
    end
  end

  task automatic mon(input logic port, input logic rdy, input logic [31:0] r,
                     input logic [3:0] f);
    if (sb.size() == 0) begin
      chk("rsp_unexpected", port, ~port);
    end else begin
      chk("rsp_port", port, sb[0].port);
      chk("rsp_result", r, sb[0].r);
      chk("rsp_flags", f, sb[0].f);
      if (rdy) void'(sb.pop_front());
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (rsp0_valid) mon(1'b0, rsp0_ready, rsp0_result, rsp0_flags);
      if (rsp1_valid) mon(1'b1, rsp1_ready, rsp1_result, rsp1_flags);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_g[6];
    reset = 1;
    idle();
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_result", {rsp0_result, rsp1_result}, 0);
    chk("reset_flags", {rsp0_flags, rsp1_flags}, 0);

    // add 5+3 on port 0
    cyc(); reset = 0; req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 0;
    @(negedge clk); chk("add_ready0", req0_ready, 1);
    cyc(); idle();
    @(negedge clk);
    chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_result", rsp0_result, 32'h8);
    chk("add_flags", rsp0_flags, 4'b0000);
    chk("add_rsp1_valid", rsp1_valid, 0);

    // sub 3-5 and 7-7 on port 1
    cyc(); req1_valid = 1; req1_a = 3; req1_b = 5; req1_op = 1;
    cyc(); idle();
    @(negedge clk);
    chk("sub_neg_result", rsp1_result, 32'hFFFF_FFFE);
    chk("sub_neg_flags", rsp1_flags, 4'b1000);
    cyc(); req1_valid = 1; req1_a = 7; req1_b = 7; req1_op = 1;
    cyc(); idle();
    @(negedge clk);
    chk("sub_zero_result", rsp1_result, 32'h0);
    chk("sub_zero_flags", rsp1_flags, 4'b0110);

    // contention for 6 cycles
    cyc(); glog.delete();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      req0_valid = 1; req1_valid = 1;
      req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom);
    end
    cyc(); idle();
    @(negedge clk);
`ifdef ALU_SHARE_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0, 0, 0};
`endif
    chk("grant_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      chk($sformatf("grant_%0d", i), glog[i], exp_g[i]);

    // backpressure on port 0 while port 1 waits
    cyc(); req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 2;
    cyc(); req0_valid = 0; rsp0_ready = 0;
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      @(negedge clk);
      chk("hold_result", rsp0_result, 32'h30);
      chk("hold_flags", rsp0_flags, 4'b0000);
      chk("hold_req1_ready", req1_ready, 0);
    end
    cyc(); rsp0_ready = 1;
    @(negedge clk); chk("release_req1_ready", req1_ready, 1);
    cyc(); req1_valid = 0;
    @(negedge clk); chk("release_rsp1_valid", rsp1_valid, 1);

    // reset while a response is held
    cyc(); idle(); req0_valid = 1; req0_a = 9; req0_b = 4; rsp0_ready = 0;
    cyc(); req0_valid = 0;
    cyc(); reset = 1;
    cyc(); reset = 0;
    @(negedge clk);
    chk("rst_mid_rsp0_valid", rsp0_valid, 0);
    chk("rst_mid_busy", busy, 0);
    cyc(); req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rst_mid_grant0", req0_ready, 1);
    chk("rst_mid_grant1", req1_ready, 0);
    cyc(); idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset      = ($urandom_range(0, 99) == 0);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      req0_a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      req1_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
      req0_op = 2'($urandom);
      req1_op = 2'($urandom);
    end

    cyc(); reset = 0; idle();
    repeat (4) cyc();
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
